// File: rtl/i2s_tx_reader_pkg.sv
// Shared I2S constants, frame-width helper and state type for the transmit read side.
package i2s_tx_reader_pkg;

    localparam int unsigned I2S_DATA_W = 16;

    // Word-select polarity: LRCLK low carries the left channel.
    localparam logic LR_LEFT  = 1'b0;
    localparam logic LR_RIGHT = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A stereo frame holds one left and one right sample.
    function automatic int unsigned i2s_frame_w(input int unsigned data_w);
        return 2 * data_w;
    endfunction

endpackage

// File: rtl/i2s_tx_reader_bclk.sv
// Bit-clock generator: divider, BCLK register and single-cycle rise/fall strobes.
module i2s_bclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    output logic bclk,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt;
    logic             tc_c;

    assign tc_c   = (div_cnt == CNT_LAST);
    assign rise_c = !hold && tc_c && !bclk;
    assign fall_c = !hold && tc_c && bclk;

    // Divider runs only while released; hold parks it at zero with BCLK low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (hold) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (tc_c) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_tx_reader.sv
// I2S master transmitter fed from the sample FIFO read port, with a one-frame shadow prefetch.
module i2s_tx_reader
    import i2s_tx_reader_pkg::*;
#(
    parameter int unsigned DATA_W  = I2S_DATA_W,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [2*DATA_W-1:0]   fifo_data,
    input  logic                  Empty,
    output logic                  Rd_En,
    output logic                  BCLK,
    output logic                  LRCLK,
    output logic                  SD,
    output logic                  underrun,
    output logic                  running
);

    localparam int unsigned      FRAME_W     = i2s_frame_w(DATA_W);
    localparam int unsigned      IDX_W       = $clog2(FRAME_W);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(FRAME_W - 1);
    localparam logic [IDX_W-1:0] IDX_R_FIRST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_R_LAST  = IDX_W'(FRAME_W - 2);

    state_t               state;
    logic                 hold_c;
    logic                 bclk_rise_c;
    logic                 bclk_fall_c;
    logic [IDX_W-1:0]     bit_idx;
    logic [IDX_W-1:0]     idx_inc_c;
    logic [IDX_W-1:0]     pre_idx;
    logic                 pre_bnd;
    logic                 pre_lr;
    logic [FRAME_W-1:0]   shift_reg;
    logic [FRAME_W-1:0]   shadow;
    logic                 shadow_valid;
    logic                 rd_pending;

    assign hold_c    = (state == ST_IDLE);
    assign idx_inc_c = (bit_idx == IDX_LAST) ? '0 : bit_idx + IDX_W'(1);

    i2s_bclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_bclk (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (hold_c),
        .bclk   (BCLK),
        .rise_c (bclk_rise_c),
        .fall_c (bclk_fall_c)
    );

    // Run/idle control, prefetch into the shadow, and serialization on BCLK falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            running      <= 1'b0;
            bit_idx      <= IDX_LAST;
            pre_idx      <= '0;
            pre_bnd      <= 1'b0;
            pre_lr       <= LR_LEFT;
            shift_reg    <= '0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            rd_pending   <= 1'b0;
            Rd_En        <= 1'b0;
            SD           <= 1'b0;
            LRCLK        <= LR_LEFT;
            underrun     <= 1'b0;
        end else begin
            underrun   <= 1'b0;
            Rd_En      <= (state == ST_RUN) && !Empty && !shadow_valid && !rd_pending && !Rd_En;
            rd_pending <= Rd_En;

            // FIFO data arrives one cycle after the strobe, even if we have gone idle.
            if (rd_pending) begin
                shadow       <= fifo_data;
                shadow_valid <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                        bit_idx <= IDX_LAST;
                    end
                end

                ST_RUN: begin
                    // Next-bit decode is precomputed half a BCLK early to keep it off the fall path.
                    if (bclk_rise_c) begin
                        pre_idx <= idx_inc_c;
                        pre_bnd <= (idx_inc_c == '0);
                        pre_lr  <= ((idx_inc_c >= IDX_R_FIRST) && (idx_inc_c <= IDX_R_LAST))
                                   ? LR_RIGHT : LR_LEFT;
                    end

                    if (bclk_fall_c) begin
                        if (pre_bnd && !enable) begin
                            state   <= ST_IDLE;
                            running <= 1'b0;
                            bit_idx <= IDX_LAST;
                            SD      <= 1'b0;
                            LRCLK   <= LR_LEFT;
                        end else begin
                            bit_idx <= pre_idx;
                            LRCLK   <= pre_lr;
                            if (pre_bnd) begin
                                if (shadow_valid) begin
                                    SD           <= shadow[FRAME_W-1];
                                    shift_reg    <= {shadow[FRAME_W-2:0], 1'b0};
                                    shadow_valid <= 1'b0;
                                end else begin
                                    SD        <= 1'b0;
                                    shift_reg <= '0;
                                    underrun  <= 1'b1;
                                end
                            end else begin
                                SD        <= shift_reg[FRAME_W-1];
                                shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
                            end
                        end
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx_reader.sv
// Scoreboard bench: stimulus queues expected frames, a monitor decodes SD/LRCLK on BCLK rises.
module tb_i2s_tx_reader;

    localparam int unsigned DW = 16;
    localparam int unsigned CD = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] fifo_data = 32'h0;
    logic        block_rd = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        Empty;
    logic        Rd_En, BCLK, LRCLK, SD, underrun, running;

    assign Empty = block_rd | fifo_empty;

    i2s_tx_reader #(.DATA_W(DW), .CLK_DIV(CD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .fifo_data (fifo_data),
        .Empty     (Empty),
        .Rd_En     (Rd_En),
        .BCLK      (BCLK),
        .LRCLK     (LRCLK),
        .SD        (SD),
        .underrun  (underrun),
        .running   (running)
    );

    always #5 clk = ~clk;

    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int rd_cnt = 0;
    int und_cnt = 0;
    int rd0 = 0;
    int und0 = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One-cycle-latency FIFO read port model.
    always @(posedge clk) begin
        if (Rd_En && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
    end

    always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);

    // Monitor: deserialize on BCLK rises, compare each completed frame against the scoreboard.
    int          cyc = 0;
    int          bit_cnt = -1;
    int          last_rise = -1;
    logic        prev_bclk = 1'b0;
    logic [31:0] acc = 32'h0;
    logic [31:0] lr = 32'h0;
    logic [31:0] exp_w;

    always @(negedge clk) begin
        cyc++;
        if (Rd_En) rd_cnt++;
        if (underrun) und_cnt++;
        if (!running) begin
            bit_cnt   = -1;
            last_rise = -1;
        end else if (BCLK && !prev_bclk) begin
            if (bit_cnt >= 0) begin
                if (last_rise >= 0) chk("bclk_period", 32'(cyc - last_rise), 32'(2 * CD));
                acc = {acc[30:0], SD};
                lr  = {lr[30:0], LRCLK};
            end
            last_rise = cyc;
            bit_cnt++;
            if (bit_cnt == 32) begin
                bit_cnt = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_unexpected: got %h expected none", acc);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("frame", acc, exp_w);
                    chk("lrclk_pattern", lr, 32'h0001_FFFE);
                end
            end
        end
        prev_bclk = BCLK;
    end

    task automatic wait_run(input logic val);
        int n = 0;
        while (running !== val && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (running !== val) begin
            errors++;
            $display("FAIL wait_running: got %b expected %b", running, val);
        end
    endtask

    task automatic snap();
        rd0  = rd_cnt;
        und0 = und_cnt;
    endtask

    task automatic end_test(input string name, input int rd_exp, input int und_exp);
        chk({name, "_rd"}, 32'(rd_cnt - rd0), 32'(rd_exp));
        chk({name, "_underrun"}, 32'(und_cnt - und0), 32'(und_exp));
        chk({name, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_bclk", 32'(BCLK), 32'd0);
        chk("rst_lrclk", 32'(LRCLK), 32'd0);
        chk("rst_sd", 32'(SD), 32'd0);
        chk("rst_rd_en", 32'(Rd_En), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame.
        snap();
        fifo_q.push_back(32'hA5A5_3C3C); exp_q.push_back(32'hA5A5_3C3C);
        repeat (2) @(negedge clk);
        enable = 1'b1; wait_run(1'b1);
        repeat (20) @(negedge clk);
        enable = 1'b0; wait_run(1'b0);
        end_test("basic", 1, 0);

        // Back-to-back frames.
        snap();
        fifo_q.push_back(32'h8000_0001); exp_q.push_back(32'h8000_0001);
        fifo_q.push_back(32'hFFFF_0000); exp_q.push_back(32'hFFFF_0000);
        repeat (2) @(negedge clk);
        enable = 1'b1; wait_run(1'b1);
        repeat (148) @(negedge clk);
        enable = 1'b0; wait_run(1'b0);
        end_test("b2b", 2, 0);

        // Underrun, then a late write.
        snap();
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        enable = 1'b1; wait_run(1'b1);
        repeat (140) @(negedge clk);
        fifo_q.push_back(32'h1234_5678); exp_q.push_back(32'h1234_5678);
        repeat (136) @(negedge clk);
        enable = 1'b0; wait_run(1'b0);
        end_test("underrun", 1, 2);

        // Disable mid-frame at b=5, shadow kept across re-entry.
        snap();
        fifo_q.push_back(32'h0123_4567); exp_q.push_back(32'h0123_4567);
        fifo_q.push_back(32'h89AB_CDEF); exp_q.push_back(32'h89AB_CDEF);
        fifo_q.push_back(32'h5555_AAAA); exp_q.push_back(32'h5555_AAAA);
        repeat (2) @(negedge clk);
        enable = 1'b1; wait_run(1'b1);
        repeat (26) @(negedge clk);
        enable = 1'b0; wait_run(1'b0);
        repeat (40) @(negedge clk);
        chk("dis_rd_hold", 32'(rd_cnt - rd0), 32'd2);
        chk("dis_bclk", 32'(BCLK), 32'd0);
        chk("dis_lrclk", 32'(LRCLK), 32'd0);
        chk("dis_sd", 32'(SD), 32'd0);
        enable = 1'b1; wait_run(1'b1);
        repeat (154) @(negedge clk);
        enable = 1'b0; wait_run(1'b0);
        end_test("disable", 3, 0);

        // Shadow capture lands on the frame-load edge.
        snap();
        block_rd = 1'b1;
        fifo_q.push_back(32'hCAFE_F00D);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'hCAFE_F00D);
        repeat (2) @(negedge clk);
        enable = 1'b1; wait_run(1'b1);
        n = 0;
        while (!underrun && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("coll_first_underrun", 32'(underrun), 32'd1);
        repeat (125) @(negedge clk);
        block_rd = 1'b0;
        repeat (151) @(negedge clk);
        enable = 1'b0; wait_run(1'b0);
        end_test("collision", 1, 2);

        // Asynchronous reset mid-frame drops the shadow.
        fifo_q.push_back(32'h0F0F_F0F0);
        fifo_q.push_back(32'h7777_1111);
        repeat (2) @(negedge clk);
        enable = 1'b1; wait_run(1'b1);
        repeat (50) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_bclk", 32'(BCLK), 32'd0);
        chk("mid_rst_lrclk", 32'(LRCLK), 32'd0);
        chk("mid_rst_sd", 32'(SD), 32'd0);
        chk("mid_rst_rd_en", 32'(Rd_En), 32'd0);
        chk("mid_rst_underrun", 32'(underrun), 32'd0);
        chk("mid_rst_running", 32'(running), 32'd0);
        repeat (2) @(negedge clk);
        fifo_q.push_back(32'hC3C3_5A5A); exp_q.push_back(32'hC3C3_5A5A);
        repeat (3) @(negedge clk);
        snap();
        rst_n = 1'b1;
        wait_run(1'b1);
        repeat (2) @(negedge clk);
        chk("first_rise_bclk", 32'(BCLK), 32'd1);
        chk("first_rise_sd", 32'(SD), 32'd0);
        chk("first_rise_lrclk", 32'(LRCLK), 32'd0);
        repeat (2) @(negedge clk);
        chk("first_fall_bclk", 32'(BCLK), 32'd0);
        chk("first_fall_sd_msb", 32'(SD), 32'd1);
        repeat (16) @(negedge clk);
        enable = 1'b0; wait_run(1'b0);
        end_test("reset", 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
